// File: rtl/three_to_eight_bit.sv
// -----------------------------------------------------------------------------
// three_to_eight_bit
//
// Registered 3-to-8 one-hot decoder with a valid/ready input side, a
// valid/ready output side and an automatic sweep mode that emits codes 0..7.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid=1 and ready=1 were both high during the preceding cycle. A
// source holding valid=1 keeps its data stable until that transfer happens.
// Ready may depend combinationally on the other side's ready.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous, active-high reset
//   y            in   3  binary code to decode
//   v            in   1  y is offered when v=1
//   ready        out  1  y is accepted this cycle when ready=1 and v=1
//   sweep_start  in   1  single-cycle request to emit codes 0..7
//   A            out  8  registered one-hot value, bit[code]=1
//   code_out     out  3  registered copy of the code that produced A
//   a_valid      out  1  A/code_out hold an unconsumed result
//   a_ready      in   1  downstream consumes when a_valid=1 and a_ready=1
//   busy         out  1  FSM state observation: 1 exactly while in SWEEP
// -----------------------------------------------------------------------------
module three_to_eight_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] y,
  input  logic       v,
  output logic       ready,
  input  logic       sweep_start,
  output logic [7:0] A,
  output logic [2:0] code_out,
  output logic       a_valid,
  input  logic       a_ready,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;

  logic       out_free;
  logic       load_in;
  logic       load_sweep;
  logic       load;
  logic [2:0] load_code;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        // The load of code 7 is the last one; leave on that same edge so the
        // counter wrap never produces a ninth result.
        if (load_sweep && (cnt == 3'd7)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM output / control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // The output register can take a new value if it is empty or is being
    // drained on this same edge.
    out_free   = !a_valid || a_ready;
    // sweep_start wins over v, so ready drops in the cycle it is requested.
    // rst is included so no handshake is advertised while reset is held.
    ready      = (state == IDLE) && !sweep_start && out_free && !rst;
    load_in    = v && ready;
    load_sweep = (state == SWEEP) && out_free;
    load       = load_in || load_sweep;
    load_code  = load_sweep ? cnt : y;
    busy       = (state == SWEEP);
  end

  // ---------------------------------------------------------------------------
  // Sweep counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if ((state == IDLE) && sweep_start) begin
      cnt <= 3'd0;
    end else if (load_sweep) begin
      cnt <= cnt + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A        <= 8'h00;
      code_out <= 3'd0;
      a_valid  <= 1'b0;
    end else if (load) begin
      A        <= 8'd1 << load_code;
      code_out <= load_code;
      a_valid  <= 1'b1;
    end else if (a_ready) begin
      // Consume without replacement: data is kept, only valid drops.
      a_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_three_to_eight_bit.sv
// -----------------------------------------------------------------------------
// tb_three_to_eight_bit
//
// Directed bench for three_to_eight_bit. Outputs are sampled 1 ns after the
// rising edge; inputs are driven at the same point. Combinational ready is
// sampled a further 1 ns after inputs change.
// -----------------------------------------------------------------------------
module tb_three_to_eight_bit;

  logic       clk;
  logic       rst;
  logic [2:0] y;
  logic       v;
  logic       ready;
  logic       sweep_start;
  logic [7:0] A;
  logic [2:0] code_out;
  logic       a_valid;
  logic       a_ready;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  three_to_eight_bit dut (
    .clk         (clk),
    .rst         (rst),
    .y           (y),
    .v           (v),
    .ready       (ready),
    .sweep_start (sweep_start),
    .A           (A),
    .code_out    (code_out),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .busy        (busy)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    int         n;
    int         iter;
    logic [7:0] exp_a;

    rst         = 1'b1;
    y           = 3'd0;
    v           = 1'b0;
    sweep_start = 1'b0;
    a_ready     = 1'b0;

    // Reset state
    #2;
    chk("rst_A",        {24'd0, A},        32'h00);
    chk("rst_code_out", {29'd0, code_out}, 32'd0);
    chk("rst_a_valid",  {31'd0, a_valid},  32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_ready",    {31'd0, ready},    32'd0);

    tick();
    rst = 1'b0;

    // Single decode of 5, first edge after reset release
    y = 3'd5; v = 1'b1; a_ready = 1'b1;
    #1;
    chk("single_ready", {31'd0, ready}, 32'd1);
    tick();
    chk("single_A",        {24'd0, A},        32'h20);
    chk("single_code_out", {29'd0, code_out}, 32'd5);
    chk("single_a_valid",  {31'd0, a_valid},  32'd1);
    v = 1'b0;
    tick();
    chk("single_drain_a_valid", {31'd0, a_valid}, 32'd0);
    chk("single_drain_A_kept",  {24'd0, A},       32'h20);

    // Full-throughput stream 0..7
    for (int i = 0; i < 8; i++) begin
      y = i[2:0]; v = 1'b1;
      #1;
      chk("stream_ready", {31'd0, ready}, 32'd1);
      tick();
      exp_a = 8'h01 << i;
      chk("stream_A",        {24'd0, A},        {24'd0, exp_a});
      chk("stream_code_out", {29'd0, code_out}, i);
      chk("stream_a_valid",  {31'd0, a_valid},  32'd1);
    end
    v = 1'b0;
    tick();
    chk("stream_end_a_valid", {31'd0, a_valid}, 32'd0);

    // Backpressure: load 2, hold it while 3 is pending, then swap back-to-back
    a_ready = 1'b0;
    y = 3'd2; v = 1'b1;
    tick();
    chk("bp_first_A", {24'd0, A}, 32'h04);
    y = 3'd3;
    #1;
    chk("bp_ready_low", {31'd0, ready}, 32'd0);
    tick();
    tick();
    chk("bp_hold_A",        {24'd0, A},        32'h04);
    chk("bp_hold_code_out", {29'd0, code_out}, 32'd2);
    chk("bp_hold_a_valid",  {31'd0, a_valid},  32'd1);
    a_ready = 1'b1;
    #1;
    chk("bp_ready_high", {31'd0, ready}, 32'd1);
    tick();
    chk("bp_swap_A",       {24'd0, A},       32'h08);
    chk("bp_swap_a_valid", {31'd0, a_valid}, 32'd1);
    v = 1'b0;
    tick();
    chk("bp_end_a_valid", {31'd0, a_valid}, 32'd0);

    // Sweep with a simultaneous v (y=6), a_ready toggling 1,0,1,...
    sweep_start = 1'b1; v = 1'b1; y = 3'd6;
    #1;
    chk("sw_start_ready", {31'd0, ready}, 32'd0);
    tick();
    sweep_start = 1'b0;
    chk("sw_busy",           {31'd0, busy},    32'd1);
    chk("sw_no_load_y6",     {31'd0, a_valid}, 32'd0);
    n    = 0;
    iter = 0;
    while ((n < 8) && (iter < 40)) begin
      a_ready     = (iter % 2 == 0);
      // A mid-sweep request must be ignored.
      sweep_start = (iter == 5);
      #1;
      if (busy) chk("sw_ready_while_busy", {31'd0, ready}, 32'd0);
      if (a_valid && a_ready) begin
        exp_a = 8'h01 << n;
        chk("sw_A",        {24'd0, A},        {24'd0, exp_a});
        chk("sw_code_out", {29'd0, code_out}, n);
        n++;
      end
      tick();
      iter++;
    end
    sweep_start = 1'b0;
    chk("sw_result_count", n, 32'd8);
    // The last result (80) was consumed on the edge just taken, and y=6 was
    // accepted on that same edge once the FSM was back in IDLE.
    chk("sw_after_busy",     {31'd0, busy},     32'd0);
    chk("sw_after_A",        {24'd0, A},        32'h40);
    chk("sw_after_code_out", {29'd0, code_out}, 32'd6);
    a_ready = 1'b1; v = 1'b0;
    tick();
    chk("sw_after_drain", {31'd0, a_valid}, 32'd0);
    tick();
    chk("sw_no_restart_busy", {31'd0, busy},    32'd0);
    chk("sw_no_extra_output", {31'd0, a_valid}, 32'd0);

    // Asynchronous reset mid-sweep after the third result
    sweep_start = 1'b1; a_ready = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    chk("rs_A1", {24'd0, A}, 32'h01);
    tick();
    chk("rs_A2", {24'd0, A}, 32'h02);
    tick();
    chk("rs_A3", {24'd0, A}, 32'h04);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_A",        {24'd0, A},        32'h00);
    chk("rs_code_out", {29'd0, code_out}, 32'd0);
    chk("rs_a_valid",  {31'd0, a_valid},  32'd0);
    chk("rs_busy",     {31'd0, busy},     32'd0);
    chk("rs_ready",    {31'd0, ready},    32'd0);
    tick();
    rst = 1'b0;
    y = 3'd0; v = 1'b1;
    tick();
    chk("rs_after_A",       {24'd0, A},       32'h01);
    chk("rs_after_a_valid", {31'd0, a_valid}, 32'd1);
    chk("rs_after_busy",    {31'd0, busy},    32'd0);
    v = 1'b0;
    tick();
    chk("rs_after_drain", {31'd0, a_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/three_to_eight_bit.md
THREE_TO_EIGHT_BIT -- requirements
Module: three_to_eight_bit

Interface
REQ-001 The block SHALL have no parameters; code width is fixed at 3 bits and one-hot width at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 y  input  3  binary code to decode.
REQ-005 v  input  1  code-valid; y is offered when v=1.
REQ-006 ready  output  1  block accepts y this cycle when ready=1 and v=1.
REQ-007 sweep_start  input  1  single-cycle request to emit codes 0..7 automatically.
REQ-008 A  output  8  registered one-hot decoded value; bit[code]=1.
REQ-009 code_out  output  3  registered copy of the code that produced A.
REQ-010 a_valid  output  1  A and code_out hold an unconsumed result.
REQ-011 a_ready  input  1  downstream consumes the result when a_valid=1 and a_ready=1.
REQ-012 busy  output  1  1 while the SWEEP state is active.

Function
REQ-013 The block SHALL have a single output register stage; a result SHALL be consumed only when a_valid=1 and a_ready=1 in the same cycle.
REQ-014 The output stage SHALL be free when a_valid=0, or when a_valid=1 and a_ready=1 in the same cycle.
REQ-015 The FSM SHALL have exactly two states, IDLE and SWEEP, with IDLE as the reset state.
REQ-016 ready SHALL be combinational and equal 1 only when the state is IDLE, sweep_start=0 and the output stage is free.
REQ-017 In IDLE, when v=1 and ready=1, the block SHALL load A=1<<y, code_out=y and a_valid=1 at the next edge, giving a latency of 1 cycle.
REQ-018 When v=0, or when ready=0, y SHALL be ignored and no input is lost; the source holds y and v until ready=1.
REQ-019 A SHALL always be one-hot while a_valid=1, and SHALL be 8'h00 only after reset.
REQ-020 While a_valid=1 and a_ready=0, A, code_out and a_valid SHALL hold unchanged.
REQ-021 A consume with no new load SHALL clear a_valid at the next edge; A and code_out SHALL keep their last value.
REQ-022 A consume and a load in the same cycle SHALL replace the result back-to-back, with a_valid staying 1 for full throughput.
REQ-023 In IDLE, sweep_start=1 SHALL move the FSM to SWEEP at the next edge and clear the 3-bit sweep counter to 0.
REQ-024 When sweep_start=1 and v=1 in the same cycle, sweep SHALL take priority, ready SHALL be 0, and y SHALL NOT be accepted.
REQ-025 In SWEEP, whenever the output stage is free, the block SHALL load A=1<<cnt and code_out=cnt, set a_valid=1, and increment cnt.
REQ-026 The load that uses cnt=7 SHALL return the FSM to IDLE, with no wrap to 0 and no extra output.
REQ-027 A sweep SHALL emit exactly 8 results in the order 01,02,04,...,80, and SHALL stall while a_ready=0 with no skipped codes.
REQ-028 sweep_start SHALL be ignored while in SWEEP.
REQ-029 v SHALL be ignored while in SWEEP because ready=0.
REQ-030 busy SHALL equal 1 exactly while the state is SWEEP.

Reset
REQ-031 rst=1 SHALL immediately force A=8'h00, code_out=3'b000, a_valid=0, busy=0, cnt=0 and state IDLE, without waiting for a clock edge.
REQ-032 While rst=1, ready SHALL be 0.
REQ-033 An assertion of rst mid-sweep SHALL abort the sweep and discard any unconsumed result.
REQ-034 After rst deasserts, the first load SHALL be possible at the first rising edge.

Verification
REQ-035 Reset then y=3'd5, v=1, a_ready=1 for one cycle -> next edge A=8'h20, code_out=5, a_valid=1; one cycle later a_valid=0.
REQ-036 a_ready=1 with y stepping 0..7, v=1 on consecutive cycles -> A sequence 01,02,04,08,10,20,40,80 on consecutive cycles, ready stays 1.
REQ-037 a_valid=1 and a_ready=0 while y=3, v=1 -> ready=0 and A holds; on a_ready=1, the held value is consumed and 8'h08 loads on the same edge.
REQ-038 sweep_start=1 and v=1 (y=6) together, a_ready toggling 1,0,1,... -> busy=1, exactly 8 results 01..80 in order, y=6 not accepted until busy=0, then A=8'h40.
REQ-039 rst asserted asynchronously after the 3rd sweep result -> outputs zero immediately, busy=0; after release, v=1 with y=0 -> A=8'h01.
